// File: rtl/zuc256_mac_defs_pkg.sv
// Shared widths, tag-length constants and FSM state encoding for the ZUC-256 MAC feeder.
package zuc256_mac_defs;

   localparam int unsigned BLOCK_W       = 128;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned LEN_W         = 8;
   localparam int unsigned BITS_W        = 6;
   localparam int unsigned CNT_W         = 3;
   localparam int unsigned WORDS_PER_BLK = 4;

   localparam logic [LEN_W-1:0] TAG_LEN_32  = 8'd32;
   localparam logic [LEN_W-1:0] TAG_LEN_64  = 8'd64;
   localparam logic [LEN_W-1:0] TAG_LEN_128 = 8'd128;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_W_INIT  = 3'd2,
      S_FILL    = 3'd3,
      S_NEXT    = 3'd4,
      S_W_NEXT  = 3'd5,
      S_FINAL   = 3'd6,
      S_W_FINAL = 3'd7
   } state_t;

endpackage

// File: rtl/zuc256_mac_word_pack.sv
// Packs 32-bit message words MSB-first into a 128-bit block, masking the
// unused tail of the final word and counting valid bits in the block.
module zuc256_mac_word_pack
   import zuc256_mac_defs::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_wr,
   input  logic [WORD_W-1:0]  i_data,
   input  logic               i_last,
   input  logic [BITS_W-1:0]  i_bits,
   output logic [BLOCK_W-1:0] o_block,
   output logic [CNT_W-1:0]   o_word_cnt,
   output logic [LEN_W-1:0]   o_blk_bits,
   output logic               o_full,
   output logic               o_partial_c
);

   logic [BLOCK_W-1:0] r_block;
   logic [CNT_W-1:0]   r_word_cnt;
   logic [LEN_W-1:0]   r_blk_bits;

   logic [BITS_W-1:0]  w_bits;
   logic [WORD_W-1:0]  w_mask;
   logic [WORD_W-1:0]  w_word;
   logic [LEN_W-1:0]   w_blk_bits_nxt;

   // Out-of-range bit counts on the last word are treated as a full word.
   always_comb begin
      w_bits = (i_bits > BITS_W'(WORD_W)) ? BITS_W'(WORD_W) : i_bits;
      w_mask = '1;
      if (i_last) begin
         w_mask = ~({WORD_W{1'b1}} >> w_bits);
      end
      w_word         = i_data & w_mask;
      w_blk_bits_nxt = r_blk_bits + (i_last ? LEN_W'(w_bits) : LEN_W'(WORD_W));
   end

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_block    <= '0;
         r_word_cnt <= '0;
         r_blk_bits <= '0;
      end else if (i_wr && !r_word_cnt[CNT_W-1]) begin
         case (r_word_cnt[1:0])
            2'd0:    r_block[127:96] <= w_word;
            2'd1:    r_block[95:64]  <= w_word;
            2'd2:    r_block[63:32]  <= w_word;
            default: r_block[31:0]   <= w_word;
         endcase
         r_word_cnt <= r_word_cnt + CNT_W'(1);
         r_blk_bits <= w_blk_bits_nxt;
      end
   end

   assign o_block     = r_block;
   assign o_word_cnt  = r_word_cnt;
   assign o_blk_bits  = r_blk_bits;
   assign o_full      = r_word_cnt[CNT_W-1];
   // Block will hold at least one valid bit once the current word lands.
   assign o_partial_c = (w_blk_bits_nxt != '0);

endmodule

// File: rtl/zuc256_mac_feeder.sv
// Feeds a message stream into the ZUC-256 MAC: packs 128-bit blocks and
// sequences init / next / final commands against the MAC ready pulse.
module zuc256_mac_feeder
   import zuc256_mac_defs::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LEN_W-1:0]   tag_len_i,
   input  logic               msg_valid,
   output logic               msg_ready,
   input  logic [WORD_W-1:0]  msg_data,
   input  logic               msg_last,
   input  logic [BITS_W-1:0]  msg_bits,
   output logic               mac_init,
   output logic               mac_next,
   output logic               mac_final,
   output logic [BLOCK_W-1:0] mac_block,
   output logic [LEN_W-1:0]   mac_i_len,
   output logic [LEN_W-1:0]   mac_tag_len,
   input  logic               mac_ready,
   output logic               busy,
   output logic               done
);

   state_t           r_state;
   logic             r_msg_ready;
   logic             r_mac_init;
   logic             r_mac_next;
   logic             r_mac_final;
   logic [LEN_W-1:0] r_mac_i_len;
   logic [LEN_W-1:0] r_tag_len;
   logic [LEN_W-1:0] r_last_len;
   logic             r_seen_last;
   logic             r_busy;
   logic             r_done;

   logic               w_accept;
   logic               w_clear;
   logic [BLOCK_W-1:0] w_block;
   logic [CNT_W-1:0]   w_word_cnt;
   logic [LEN_W-1:0]   w_blk_bits;
   logic               w_full;
   logic               w_partial;

   assign w_accept = (r_state == S_FILL) && msg_valid && r_msg_ready && !w_full;
   assign w_clear  = ((r_state == S_IDLE) && start) ||
                     ((r_state == S_W_NEXT) && mac_ready && !r_seen_last);

   zuc256_mac_word_pack u_pack (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_wr        (w_accept),
      .i_data      (msg_data),
      .i_last      (msg_last),
      .i_bits      (msg_bits),
      .o_block     (w_block),
      .o_word_cnt  (w_word_cnt),
      .o_blk_bits  (w_blk_bits),
      .o_full      (w_full),
      .o_partial_c (w_partial)
   );

   // Command FSM; pulses are raised on entry so they coincide with the command state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_msg_ready <= 1'b0;
         r_mac_init  <= 1'b0;
         r_mac_next  <= 1'b0;
         r_mac_final <= 1'b0;
         r_mac_i_len <= '0;
         r_tag_len   <= '0;
         r_last_len  <= '0;
         r_seen_last <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_mac_init  <= 1'b0;
         r_mac_next  <= 1'b0;
         r_mac_final <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tag_len   <= tag_len_i;
                  r_last_len  <= '0;
                  r_seen_last <= 1'b0;
                  r_mac_i_len <= '0;
                  r_mac_init  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_INIT;
               end
            end
            S_INIT: r_state <= S_W_INIT;
            S_W_INIT: begin
               if (mac_ready) begin
                  r_msg_ready <= 1'b1;
                  r_state     <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_seen_last <= msg_last;
                  // An empty trailing block skips next; final reports the previous block.
                  if (msg_last && !w_partial) begin
                     r_msg_ready <= 1'b0;
                     r_mac_i_len <= r_last_len;
                     r_mac_final <= 1'b1;
                     r_state     <= S_FINAL;
                  end else if (msg_last || (w_word_cnt == CNT_W'(WORDS_PER_BLK - 1))) begin
                     r_msg_ready <= 1'b0;
                     r_mac_next  <= 1'b1;
                     r_state     <= S_NEXT;
                  end
               end
            end
            S_NEXT: begin
               r_last_len <= w_blk_bits;
               r_state    <= S_W_NEXT;
            end
            S_W_NEXT: begin
               if (mac_ready) begin
                  if (r_seen_last) begin
                     r_mac_i_len <= r_last_len;
                     r_mac_final <= 1'b1;
                     r_state     <= S_FINAL;
                  end else begin
                     r_msg_ready <= 1'b1;
                     r_state     <= S_FILL;
                  end
               end
            end
            S_FINAL: r_state <= S_W_FINAL;
            S_W_FINAL: begin
               if (mac_ready) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign msg_ready   = r_msg_ready;
   assign mac_init    = r_mac_init;
   assign mac_next    = r_mac_next;
   assign mac_final   = r_mac_final;
   assign mac_block   = w_block;
   assign mac_i_len   = r_mac_i_len;
   assign mac_tag_len = r_tag_len;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_zuc256_mac_feeder.sv
// Bench for zuc256_mac_feeder: directed and random messages checked against a
// bit-length based block model, with a MAC responder that records commands.
module tb_zuc256_mac_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, start, msg_valid, msg_ready, msg_last;
   logic         mac_init, mac_next, mac_final, mac_ready, busy, done;
   logic [7:0]   tag_len_i, mac_i_len, mac_tag_len;
   logic [31:0]  msg_data;
   logic [5:0]   msg_bits;
   logic [127:0] mac_block;

   typedef struct {
      int           kind;
      logic [127:0] blk;
      logic [7:0]   len;
      logic [7:0]   tag;
   } ev_t;

   ev_t         ev_q[$];
   logic [31:0] msg_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   bit          stray_en = 1'b0;
   bit          slow = 1'b0;
   bit          abort_rsp = 1'b0;

   zuc256_mac_feeder dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .tag_len_i   (tag_len_i),
      .msg_valid   (msg_valid),
      .msg_ready   (msg_ready),
      .msg_data    (msg_data),
      .msg_last    (msg_last),
      .msg_bits    (msg_bits),
      .mac_init    (mac_init),
      .mac_next    (mac_next),
      .mac_final   (mac_final),
      .mac_block   (mac_block),
      .mac_i_len   (mac_i_len),
      .mac_tag_len (mac_tag_len),
      .mac_ready   (mac_ready),
      .busy        (busy),
      .done        (done)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // MAC model: logs each command, answers 1..3 cycles later, optionally injects stray ready.
   initial begin : rsp
      ev_t e;
      int  k;
      bit  ab;
      mac_ready = 1'b0;
      forever begin
         @(negedge clk);
         mac_ready = 1'b0;
         if (done) begin
            done_cnt++;
            check_eq("busy_at_done", 128'(busy), 128'(0));
         end
         if (mac_init || mac_next || mac_final) begin
            check_eq("one_cmd", 128'($countones({mac_init, mac_next, mac_final})), 128'(1));
            e.kind = mac_init ? 0 : (mac_next ? 1 : 2);
            e.blk  = mac_block;
            e.len  = mac_i_len;
            e.tag  = mac_tag_len;
            ev_q.push_back(e);
            if (e.kind == 1) check_eq("rdy_low_next", 128'(msg_ready), 128'(0));
            k  = slow ? 3 : int'($urandom_range(1, 3));
            ab = 1'b0;
            for (int j = 0; j < k && !ab; j++) begin
               @(negedge clk);
               if (abort_rsp) begin
                  ab        = 1'b1;
                  abort_rsp = 1'b0;
               end else begin
                  check_eq("cmd_quiet", 128'({mac_init, mac_next, mac_final}), 128'(0));
                  check_eq("hold_blk", mac_block, e.blk);
                  check_eq("hold_len", 128'({mac_i_len, mac_tag_len}), 128'({e.len, e.tag}));
                  if (e.kind == 1) check_eq("rdy_low_wait", 128'(msg_ready), 128'(0));
               end
            end
            if (!ab) mac_ready = 1'b1;
         end else if (stray_en && ($urandom_range(0, 4) == 0)) begin
            mac_ready = 1'b1;
         end
      end
   end

   task automatic send_words(input int bits, input bit hold, input bit glitch, input bit has_last);
      int i = 0;
      int g = 0;
      int n = msg_q.size();
      while (i < n && g < 3000) begin
         @(negedge clk);
         g++;
         msg_valid = hold || ($urandom_range(0, 3) != 0);
         msg_data  = msg_valid ? msg_q[i] : $urandom;
         msg_last  = has_last && (i == n - 1);
         msg_bits  = msg_last ? 6'(bits) : 6'($urandom_range(0, 32));
         start     = glitch && ($urandom_range(0, 4) == 0);
         if (glitch) tag_len_i = 8'($urandom);
         if (msg_valid && msg_ready) i++;
      end
      if (i < n) check_eq("send_timeout", 128'(i), 128'(n));
      @(negedge clk);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      start     = 1'b0;
   endtask

   // Reference: total bit length decides block count and final length; block k is words 4k..4k+3.
   task automatic run_msg(input int bits, input logic [7:0] tag, input bit hold, input bit glitch);
      int           n, total, nb, flen, g;
      logic [31:0]  mw[$];
      logic [127:0] eb[$];
      logic [127:0] blk;
      logic [63:0]  t;
      n     = msg_q.size();
      total = 32 * (n - 1) + bits;
      nb    = (total + 127) / 128;
      flen  = (total == 0) ? 0 : total - 128 * (nb - 1);
      for (int i = 0; i < n; i++) begin
         t = {32'h0, msg_q[i]};
         if (i == n - 1) t = (t >> (32 - bits)) << (32 - bits);
         mw.push_back(t[31:0]);
      end
      for (int k = 0; k < nb; k++) begin
         blk = '0;
         for (int j = 0; j < 4; j++)
            blk = {blk[95:0], ((4 * k + j) < n) ? mw[4 * k + j] : 32'h0};
         eb.push_back(blk);
      end
      ev_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start     = 1'b1;
      tag_len_i = tag;
      @(negedge clk);
      start = 1'b0;
      check_eq("init_lat", 128'(mac_init), 128'(1));
      send_words(bits, hold, glitch, 1'b1);
      g = 0;
      while (done_cnt == 0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check_eq("done_seen", 128'(done_cnt), 128'(1));
      check_eq("ev_count", 128'(ev_q.size()), 128'(nb + 2));
      if (ev_q.size() == nb + 2) begin
         check_eq("kind_init", 128'(ev_q[0].kind), 128'(0));
         for (int k = 0; k < nb; k++) begin
            check_eq("kind_next", 128'(ev_q[k + 1].kind), 128'(1));
            check_eq("next_blk", ev_q[k + 1].blk, eb[k]);
         end
         check_eq("kind_final", 128'(ev_q[nb + 1].kind), 128'(2));
         check_eq("final_len", 128'(ev_q[nb + 1].len), 128'(flen));
         check_eq("final_tag", 128'(ev_q[nb + 1].tag), 128'(tag));
      end
   endtask

   initial begin : main
      logic [7:0] tags[3];
      tags[0]   = 8'd32;
      tags[1]   = 8'd64;
      tags[2]   = 8'd128;
      reset     = 1'b1;
      start     = 1'b0;
      tag_len_i = 8'h0;
      msg_valid = 1'b0;
      msg_data  = 32'h0;
      msg_last  = 1'b0;
      msg_bits  = 6'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_ctl", 128'({busy, msg_ready, mac_init, mac_next, mac_final, done}), 128'(0));
      check_eq("rst_blk", mac_block, 128'(0));
      check_eq("rst_len", 128'({mac_i_len, mac_tag_len}), 128'(0));

      // Single full block.
      msg_q = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
      run_msg(32, 8'd32, 1'b0, 1'b0);
      if (ev_q.size() > 1)
         check_eq("tp1_blk", ev_q[1].blk, 128'h0123456789ABCDEFFEDCBA9876543210);

      // Partial second block with 8 valid bits.
      msg_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hAB123456};
      run_msg(8, 8'd64, 1'b0, 1'b0);
      if (ev_q.size() > 2)
         check_eq("tp2_blk", ev_q[2].blk, 128'hAB000000_00000000_00000000_00000000);

      // Empty message.
      msg_q = '{32'hDEADBEEF};
      run_msg(0, 8'd128, 1'b0, 1'b0);

      // Exactly one full block then an empty last word.
      msg_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hFFFFFFFF};
      run_msg(0, 8'd32, 1'b0, 1'b0);

      // Continuous valid across several blocks.
      msg_q.delete();
      for (int i = 0; i < 9; i++) msg_q.push_back($urandom);
      run_msg(17, 8'd64, 1'b1, 1'b0);

      // Start during busy and stray ready pulses.
      stray_en = 1'b1;
      msg_q.delete();
      for (int i = 0; i < 7; i++) msg_q.push_back($urandom);
      run_msg(32, 8'd128, 1'b0, 1'b1);
      stray_en = 1'b0;

      // Reset while waiting on next.
      slow  = 1'b1;
      msg_q = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
      ev_q.delete();
      @(negedge clk);
      start     = 1'b1;
      tag_len_i = 8'd128;
      @(negedge clk);
      start = 1'b0;
      send_words(0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset     = 1'b1;
      abort_rsp = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("mid_rst_ctl", 128'({busy, msg_ready, mac_init, mac_next, mac_final, done}), 128'(0));
      check_eq("mid_rst_blk", mac_block, 128'(0));
      check_eq("mid_rst_len", 128'({mac_i_len, mac_tag_len}), 128'(0));
      ev_q.delete();
      repeat (4) @(negedge clk);
      check_eq("no_cmd_after_rst", 128'(ev_q.size()), 128'(0));
      slow  = 1'b0;
      msg_q = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4};
      run_msg(20, 8'd64, 1'b0, 1'b0);

      // Random messages.
      for (int r = 0; r < 14; r++) begin
         int n;
         int b;
         n = int'($urandom_range(1, 10));
         b = int'($urandom_range(0, 32));
         msg_q.delete();
         for (int i = 0; i < n; i++) msg_q.push_back($urandom);
         stray_en = 1'($urandom_range(0, 1));
         run_msg(b, tags[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      stray_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
